// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the RAM access arbiter.
// Holds the arbiter FSM state encoding and the default video starvation limit.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    BUS_ACCESS   = 2'd1,
    VIDEO_ACCESS = 2'd2,
    BUS_HOLD     = 2'd3
  } arb_state_t;

  localparam int VIDEO_STARVE_LIMIT_DEFAULT = 4;

endpackage

// File: rtl/ram_access_arbiter.sv
// Arbitrates a single backend RAM port between the CPU bus and video fetch.
// The bus normally wins; video is forced through after VIDEO_STARVE_LIMIT consecutive losses.
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int VIDEO_STARVE_LIMIT = VIDEO_STARVE_LIMIT_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memory_read_n,
  input  logic        memory_write_n,
  input  logic [19:0] address,
  input  logic [7:0]  internal_data_bus,
  output logic [7:0]  data_bus_out,
  output logic        memory_access_ready,
  input  logic        video_request,
  input  logic [19:0] video_address,
  output logic        video_acknowledge,
  output logic [7:0]  video_data,
  output logic        mem_request,
  output logic        mem_write,
  output logic [19:0] mem_address,
  output logic [7:0]  mem_write_data,
  input  logic [7:0]  mem_read_data,
  input  logic        mem_done
);

  localparam int CNT_W = (VIDEO_STARVE_LIMIT > 1) ? $clog2(VIDEO_STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(VIDEO_STARVE_LIMIT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    return (value >= LIMIT) ? LIMIT : value + 1'b1;
  endfunction

  arb_state_t       state, next_state;
  logic             bus_served;
  logic [CNT_W-1:0] starve_count;

  logic strobe_any, strobes_idle, bus_pending;
  logic video_wins, bus_wins, done_p0;
  logic grant_bus, grant_video, bus_done, video_done;

  assign strobe_any          = ~memory_read_n | ~memory_write_n;
  assign strobes_idle        = memory_read_n & memory_write_n;
  assign bus_pending         = strobe_any & ~bus_served;
  assign memory_access_ready = ~bus_pending;

  // Video takes the slot when the bus is quiet or once it has been starved long enough.
  assign video_wins = video_request & (~bus_pending | (starve_count >= LIMIT));
  assign bus_wins   = bus_pending & ~video_wins;
  assign done_p0    = mem_done & mem_request;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    grant_bus   = 1'b0;
    grant_video = 1'b0;
    bus_done    = 1'b0;
    video_done  = 1'b0;
    case (state)
      IDLE: begin
        if (bus_wins) begin
          grant_bus  = 1'b1;
          next_state = BUS_ACCESS;
        end else if (video_wins) begin
          grant_video = 1'b1;
          next_state  = VIDEO_ACCESS;
        end
      end
      BUS_ACCESS: begin
        if (done_p0) begin
          bus_done   = 1'b1;
          next_state = BUS_HOLD;
        end
      end
      VIDEO_ACCESS: begin
        if (done_p0) begin
          video_done = 1'b1;
          next_state = IDLE;
        end
      end
      BUS_HOLD: begin
        if (strobes_idle) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Backend request and captured read data, updated on grants and completions.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_request       <= 1'b0;
      mem_write         <= 1'b0;
      mem_address       <= '0;
      mem_write_data    <= '0;
      data_bus_out      <= '0;
      video_data        <= '0;
      video_acknowledge <= 1'b0;
      bus_served        <= 1'b0;
      starve_count      <= '0;
    end else begin
      video_acknowledge <= video_done;

      if (grant_bus) begin
        mem_request    <= 1'b1;
        mem_write      <= ~memory_write_n;
        mem_address    <= address;
        mem_write_data <= internal_data_bus;
      end else if (grant_video) begin
        mem_request <= 1'b1;
        mem_write   <= 1'b0;
        mem_address <= video_address;
      end else if (bus_done || video_done) begin
        mem_request <= 1'b0;
      end

      if (bus_done && !mem_write) data_bus_out <= mem_read_data;
      if (video_done)             video_data   <= mem_read_data;

      // Completion wins over release so an aborted cycle still passes through BUS_HOLD.
      if (bus_done)          bus_served <= 1'b1;
      else if (strobes_idle) bus_served <= 1'b0;

      if (grant_video)                    starve_count <= '0;
      else if (grant_bus && video_request) starve_count <= sat_inc(starve_count);
    end
  end

endmodule
